// File: rtl/r4_stage_seq.sv
// Control sequencer for one radix-4 FFT stage. It turns a valid-qualified sample
// stream into per-sample block/stage syncs and k1/k2 segment bits, one cycle later.
module r4_stage_seq #(
    parameter int LDN_MIN = 8,
    parameter int LDN_MAX = 11,
    parameter int CNT_W   = 11
) (
    input  logic       clk_sys,
    input  logic       rst_sys,
    input  logic       block_start_i,
    input  logic       data_val_i,
    input  logic [3:0] ldn_rg_i,
    output logic       block_sync_o,
    output logic       stage_sync_o,
    output logic       data_val_o,
    output logic       k1_o,
    output logic       k2_o,
    output logic       last_o,
    output logic [3:0] ldn_rg_o,
    output logic       busy_o,
    output logic       cfg_err_o,
    output logic       overrun_o,
    output logic       orphan_o
);

    // Stream semantics: there is no back-pressure. A sample is transferred in every
    // cycle where data_val_i is high; block_start_i has meaning only in such a cycle.

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [3:0] LDN_LO = 4'(LDN_MIN);
    localparam logic [3:0] LDN_HI = 4'(LDN_MAX);

    state_t           state;
    logic [CNT_W-1:0] c_cnt;

    logic             start_req;
    logic             start_ok;
    logic             accept;
    logic [3:0]       ldn_cur;
    logic [CNT_W-1:0] c_cur;
    logic [1:0]       q_idx;
    logic             span_first;
    logic             last_hit;

    // The state flop drives busy_o directly, so the FSM state is visible at the port.
    assign busy_o = (state == RUN);

    always_comb begin
        start_req  = block_start_i & data_val_i;
        start_ok   = (state == IDLE) & start_req & (ldn_rg_i >= LDN_LO) & (ldn_rg_i <= LDN_HI);
        accept     = start_ok | ((state == RUN) & data_val_i);
        ldn_cur    = (state == RUN) ? ldn_rg_o : ldn_rg_i;
        c_cur      = (state == RUN) ? c_cnt : '0;
        // Odd ldn (9, 11) uses a 128-sample quarter, even ldn (8, 10) uses 64.
        if (ldn_cur[0]) begin
            q_idx      = c_cur[8:7];
            span_first = (c_cur[8:0] == 9'd0);
        end else begin
            q_idx      = c_cur[7:6];
            span_first = (c_cur[7:0] == 8'd0);
        end
        last_hit   = ({1'b0, c_cur} == (((CNT_W+1)'(1) << ldn_cur) - (CNT_W+1)'(1)));
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            state        <= IDLE;
            c_cnt        <= '0;
            ldn_rg_o     <= '0;
            block_sync_o <= 1'b0;
            stage_sync_o <= 1'b0;
            data_val_o   <= 1'b0;
            k1_o         <= 1'b0;
            k2_o         <= 1'b0;
            last_o       <= 1'b0;
            cfg_err_o    <= 1'b0;
            overrun_o    <= 1'b0;
            orphan_o     <= 1'b0;
        end else begin
            data_val_o   <= accept;
            k1_o         <= accept & q_idx[1];
            k2_o         <= accept & q_idx[0];
            stage_sync_o <= accept & span_first;
            block_sync_o <= accept & (c_cur == '0);
            last_o       <= accept & last_hit;
            overrun_o    <= (state == RUN) & start_req;
            orphan_o     <= (state == IDLE) & data_val_i & ~block_start_i;
            if ((state == IDLE) & start_req & ~start_ok) begin
                cfg_err_o <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        ldn_rg_o <= ldn_rg_i;
                        c_cnt    <= (CNT_W)'(1);
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (data_val_i) begin
                        if (last_hit) begin
                            c_cnt <= '0;
                            state <= IDLE;
                        end else begin
                            c_cnt <= c_cnt + (CNT_W)'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_r4_stage_seq.sv
// Directed and random stimulus for r4_stage_seq, checked cycle by cycle against a
// sample-level model of the block/stage arithmetic.
module tb_r4_stage_seq;

    logic       clk_sys = 1'b0;
    logic       rst_sys = 1'b0;
    logic       block_start_i = 1'b0;
    logic       data_val_i = 1'b0;
    logic [3:0] ldn_rg_i = 4'd0;
    logic       block_sync_o, stage_sync_o, data_val_o, k1_o, k2_o, last_o;
    logic [3:0] ldn_rg_o;
    logic       busy_o, cfg_err_o, overrun_o, orphan_o;

    int total = 0;
    int bad = 0;
    int n_dv = 0;
    int n_ss = 0;

    // Model state: block in progress, latched size, next sample index, sticky error.
    logic       m_busy = 1'b0;
    logic [3:0] m_ldn = 4'd0;
    int         m_c = 0;
    logic       m_cfg = 1'b0;
    logic [13:0] exp_q[$];

    r4_stage_seq dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .block_start_i(block_start_i),
        .data_val_i(data_val_i), .ldn_rg_i(ldn_rg_i), .block_sync_o(block_sync_o),
        .stage_sync_o(stage_sync_o), .data_val_o(data_val_o), .k1_o(k1_o), .k2_o(k2_o),
        .last_o(last_o), .ldn_rg_o(ldn_rg_o), .busy_o(busy_o), .cfg_err_o(cfg_err_o),
        .overrun_o(overrun_o), .orphan_o(orphan_o)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs one cycle after these inputs, from block-level arithmetic.
    task automatic model(input logic r, input logic st, input logic v, input logic [3:0] l);
        logic bs, ss, dv, k1, k2, la, ov, orp, take;
        int qs, nn, q;
        {bs, ss, dv, k1, k2, la, ov, orp, take} = '0;
        if (r) begin
            m_busy = 1'b0; m_ldn = 4'd0; m_c = 0; m_cfg = 1'b0;
        end else if (!m_busy) begin
            if (v && st) begin
                if (l >= 4'd8 && l <= 4'd11) begin
                    m_busy = 1'b1; m_ldn = l; m_c = 0; take = 1'b1;
                end else begin
                    m_cfg = 1'b1;
                end
            end else if (v) begin
                orp = 1'b1;
            end
        end else begin
            ov   = st && v;
            take = v;
        end
        if (take) begin
            nn = 1 << m_ldn;
            qs = (m_ldn % 2 == 1) ? 128 : 64;
            q  = (m_c / qs) % 4;
            dv = 1'b1;
            k1 = (q / 2) != 0;
            k2 = (q % 2) != 0;
            ss = (m_c % (4 * qs)) == 0;
            bs = (m_c == 0);
            la = (m_c == nn - 1);
            m_c++;
            if (la) m_busy = 1'b0;
        end
        exp_q.push_back({bs, ss, dv, k1, k2, la, m_busy, m_cfg, ov, orp, m_ldn});
    endtask

    task automatic step(input logic r, input logic st, input logic v, input logic [3:0] l);
        logic [13:0] e;
        rst_sys = r; block_start_i = st; data_val_i = v; ldn_rg_i = l;
        model(r, st, v, l);
        @(posedge clk_sys);
        #1;
        e = exp_q.pop_front();
        chk("block_sync", 4'(block_sync_o), 4'(e[13]));
        chk("stage_sync", 4'(stage_sync_o), 4'(e[12]));
        chk("data_val", 4'(data_val_o), 4'(e[11]));
        chk("k1", 4'(k1_o), 4'(e[10]));
        chk("k2", 4'(k2_o), 4'(e[9]));
        chk("last", 4'(last_o), 4'(e[8]));
        chk("busy", 4'(busy_o), 4'(e[7]));
        chk("cfg_err", 4'(cfg_err_o), 4'(e[6]));
        chk("overrun", 4'(overrun_o), 4'(e[5]));
        chk("orphan", 4'(orphan_o), 4'(e[4]));
        chk("ldn_rg", ldn_rg_o, e[3:0]);
        n_dv += int'(data_val_o);
        n_ss += int'(stage_sync_o);
    endtask

    function automatic logic [3:0] noise();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic run_block(input logic [3:0] l, input int n);
        step(1'b0, 1'b1, 1'b1, l);
        for (int i = 1; i < n; i++) step(1'b0, 1'b0, 1'b1, noise());
    endtask

    initial begin
        // Reset state
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b0, 1'b0, 4'd0);

        // ldn=8 contiguous block, one stage span
        n_dv = 0; n_ss = 0;
        run_block(4'd8, 256);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("ldn8_dv_count", 4'(n_dv == 256), 4'd1);
        chk("ldn8_ss_count", 4'(n_ss), 4'd1);

        // ldn=11 with valid toggling 1,0
        n_dv = 0; n_ss = 0;
        for (int i = 0; i < 4096; i++) step(1'b0, i == 0, (i % 2) == 0, (i == 0) ? 4'd11 : noise());
        step(1'b0, 1'b0, 1'b0, 4'd0);
        chk("ldn11_dv_count", 4'(n_dv == 2048), 4'd1);
        chk("ldn11_ss_count", 4'(n_ss), 4'd4);

        // ldn=9 then ldn=10 back-to-back
        run_block(4'd9, 512);
        run_block(4'd10, 1024);
        step(1'b0, 1'b0, 1'b0, 4'd0);

        // Illegal sizes, then a legal block
        step(1'b0, 1'b1, 1'b1, 4'd7);
        step(1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 1'b1, 4'd12);
        step(1'b0, 1'b1, 1'b0, 4'd8);
        run_block(4'd8, 256);
        step(1'b0, 1'b0, 1'b0, 4'd0);

        // Overrun start at sample 300 of an ldn=10 block
        step(1'b0, 1'b1, 1'b1, 4'd10);
        for (int i = 1; i < 1024; i++) step(1'b0, i == 300, 1'b1, noise());
        step(1'b0, 1'b0, 1'b0, 4'd0);

        // Reset mid-block, then an orphan sample
        step(1'b1, 1'b0, 1'b0, 4'd0);
        run_block(4'd8, 100);
        step(1'b1, 1'b0, 1'b1, 4'd8);
        step(1'b0, 1'b0, 1'b1, 4'd8);
        step(1'b0, 1'b0, 1'b0, 4'd0);

        // Random traffic: stray starts, gaps, odd sizes, rare resets
        for (int i = 0; i < 12000; i++) begin
            step($urandom_range(0, 2999) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 3) != 0, 4'($urandom_range(6, 12)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
